// File: rtl/mmio_io_pkg.sv
// Shared definitions for the board I/O controller: register offsets,
// the 7-segment code type and the hex-glyph encoder.
package mmio_io_pkg;

   localparam logic [3:0] OFS_LED      = 4'h0;
   localparam logic [3:0] OFS_HEX_LO   = 4'h1;
   localparam logic [3:0] OFS_HEX_HI   = 4'h2;
   localparam logic [3:0] OFS_HEX_CTRL = 4'h3;
   localparam logic [3:0] OFS_SW       = 4'h4;
   localparam logic [3:0] OFS_SW_EDGE  = 4'h5;
   localparam logic [3:0] OFS_TIMER    = 4'h6;

   // Active-low segments: bit 7 = DP, bits 6:0 = g..a.
   typedef logic [7:0] seg7_t;

   function automatic seg7_t hex_to_seg7(input logic [3:0] nib, input logic dp);
      logic [6:0] glyph;
      case (nib)
         4'h0:    glyph = 7'h40;
         4'h1:    glyph = 7'h79;
         4'h2:    glyph = 7'h24;
         4'h3:    glyph = 7'h30;
         4'h4:    glyph = 7'h19;
         4'h5:    glyph = 7'h12;
         4'h6:    glyph = 7'h02;
         4'h7:    glyph = 7'h78;
         4'h8:    glyph = 7'h00;
         4'h9:    glyph = 7'h10;
         4'hA:    glyph = 7'h08;
         4'hB:    glyph = 7'h03;
         4'hC:    glyph = 7'h46;
         4'hD:    glyph = 7'h21;
         4'hE:    glyph = 7'h06;
         default: glyph = 7'h0E;
      endcase
      return {~dp, glyph};
   endfunction

endpackage

// File: rtl/sw_debounce.sv
// One switch bit: two-flop synchroniser, stability counter, debounced level
// and a single-cycle pulse asserted on the edge where the level rises.
module sw_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic CLK,
   input  logic RST,
   input  logic raw,
   output logic deb,
   output logic rise
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_p0;
   logic             sync_p1;
   logic [CNT_W-1:0] cnt;
   logic             settle;

   // rise is combinational so the flag register captures it on the same
   // edge that deb itself goes high.
   assign settle = (sync_p1 != deb) && (cnt == CNT_LAST);
   assign rise   = settle && sync_p1;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         cnt     <= '0;
         deb     <= 1'b0;
      end else begin
         // stage p0 -> p1: metastability filter
         sync_p0 <= raw;
         sync_p1 <= sync_p0;
         if (sync_p1 == deb) begin
            cnt <= '0;
         end else if (settle) begin
            deb <= sync_p1;
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped LED / 7-segment / switch / timer controller on the CPU data port.
// Build option: define MMIO_TIMER_EN to include the TIMER register and its counter.
module mmio_io_ctrl
   import mmio_io_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR       = 16'hFF00,
   parameter int          DEBOUNCE_CYCLES = 16
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [15:0] bus_addr,
   input  logic [15:0] bus_wdata,
   input  logic        bus_we,
   input  logic        bus_re,
   output logic [15:0] bus_rdata,
   output logic        bus_hit,
   input  logic [9:0]  SW,
   output logic [9:0]  LEDS,
   output seg7_t       HEX0,
   output seg7_t       HEX1,
   output seg7_t       HEX2,
   output seg7_t       HEX3,
   output seg7_t       HEX4,
   output seg7_t       HEX5
);

   logic [3:0]  ofs;
   logic        wr;
   logic        rd;
   logic [9:0]  led_reg;
   logic [11:0] hex_lo;
   logic [11:0] hex_hi;
   logic [5:0]  blank;
   logic [5:0]  dp;
   logic [9:0]  sw_deb;
   logic [9:0]  sw_rise;
   logic [9:0]  edge_flags;
   logic [9:0]  edge_clr;
   logic [23:0] digits;
   seg7_t       seg_p0 [6];
   seg7_t       seg_p1 [6];

   assign bus_hit  = (bus_addr[15:4] == BASE_ADDR[15:4]);
   assign ofs      = bus_addr[3:0];
   assign wr       = bus_we && bus_hit;
   assign rd       = bus_re && bus_hit;
   assign edge_clr = (wr && ofs == OFS_SW_EDGE) ? bus_wdata[9:0] : 10'd0;
   assign digits   = {hex_hi, hex_lo};

   for (genvar g = 0; g < 10; g++) begin : g_deb
      sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .CLK  (CLK),
         .RST  (RST),
         .raw  (SW[g]),
         .deb  (sw_deb[g]),
         .rise (sw_rise[g])
      );
   end

   for (genvar g = 0; g < 6; g++) begin : g_seg
      assign seg_p0[g] = blank[g] ? 8'hFF : hex_to_seg7(digits[4*g +: 4], dp[g]);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         led_reg    <= '0;
         hex_lo     <= '0;
         hex_hi     <= '0;
         blank      <= 6'h3F;
         dp         <= '0;
         edge_flags <= '0;
      end else begin
         if (wr) begin
            case (ofs)
               OFS_LED:      led_reg <= bus_wdata[9:0];
               OFS_HEX_LO:   hex_lo  <= bus_wdata[11:0];
               OFS_HEX_HI:   hex_hi  <= bus_wdata[11:0];
               OFS_HEX_CTRL: begin
                  blank <= bus_wdata[5:0];
                  dp    <= bus_wdata[13:8];
               end
               default: ;
            endcase
         end
         // a rise arriving together with a W1C clear must survive
         edge_flags <= (edge_flags & ~edge_clr) | sw_rise;
      end
   end

   // stage p0 -> p1: displays follow the registers one edge later
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < 6; i++) seg_p1[i] <= 8'hFF;
      end else begin
         for (int i = 0; i < 6; i++) seg_p1[i] <= seg_p0[i];
      end
   end

   assign LEDS = led_reg;
   assign HEX0 = seg_p1[0];
   assign HEX1 = seg_p1[1];
   assign HEX2 = seg_p1[2];
   assign HEX3 = seg_p1[3];
   assign HEX4 = seg_p1[4];
   assign HEX5 = seg_p1[5];

`ifdef MMIO_TIMER_EN
   logic [15:0] timer;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         timer <= '0;
      end else if (wr && ofs == OFS_TIMER) begin
         timer <= bus_wdata;
      end else begin
         timer <= timer + 16'd1;
      end
   end
`else
   logic unused_wdata;
   assign unused_wdata = &{1'b0, bus_wdata[15:14]};
`endif

   always_comb begin
      bus_rdata = '0;
      if (rd) begin
         case (ofs)
            OFS_LED:      bus_rdata = {6'd0, led_reg};
            OFS_HEX_LO:   bus_rdata = {4'd0, hex_lo};
            OFS_HEX_HI:   bus_rdata = {4'd0, hex_hi};
            OFS_HEX_CTRL: bus_rdata = {2'd0, dp, 2'd0, blank};
            OFS_SW:       bus_rdata = {6'd0, sw_deb};
            OFS_SW_EDGE:  bus_rdata = {6'd0, edge_flags};
`ifdef MMIO_TIMER_EN
            OFS_TIMER:    bus_rdata = timer;
`endif
            default:      bus_rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Scoreboard bench for mmio_io_ctrl: driver pushes expectations from a
// behavioural model, a negedge monitor pops and compares.
module tb_mmio_io_ctrl;

   localparam int N = 16;
`ifdef MMIO_TIMER_EN
   localparam bit TEN = 1'b1;
`else
   localparam bit TEN = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [15:0] bus_addr = '0;
   logic [15:0] bus_wdata = '0;
   logic        bus_we = 1'b0;
   logic        bus_re = 1'b0;
   logic [15:0] bus_rdata;
   logic        bus_hit;
   logic [9:0]  SW = '0;
   logic [9:0]  LEDS;
   logic [7:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

   mmio_io_ctrl #(.BASE_ADDR(16'hFF00), .DEBOUNCE_CYCLES(N)) dut (
      .CLK(CLK), .RST(RST), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_we(bus_we), .bus_re(bus_re), .bus_rdata(bus_rdata), .bus_hit(bus_hit),
      .SW(SW), .LEDS(LEDS), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2),
      .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [15:0] rd;
      logic        hit;
      logic [9:0]  leds;
      logic [47:0] hex;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // reference state
   logic [6:0]  glyph [16];
   logic [9:0]  m_led, m_deb, m_flags;
   logic [11:0] m_hlo, m_hhi;
   logic [5:0]  m_blank, m_dp;
   logic [15:0] m_timer;
   logic [7:0]  m_hex [6];
   logic [9:0]  rawq[$];
   logic [9:0]  sq[$];
   logic        p_we;
   logic [15:0] p_addr, p_wdata;
   logic [9:0]  p_sw;

   task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_led = '0; m_hlo = '0; m_hhi = '0; m_blank = 6'h3F; m_dp = '0;
      m_deb = '0; m_flags = '0; m_timer = '0;
      for (int i = 0; i < 6; i++) m_hex[i] = 8'hFF;
      rawq.delete();
      sq.delete();
   endtask

   // Advance the model across one clock edge using the inputs sampled there.
   task automatic model_edge();
      logic [7:0]  hx [6];
      logic [3:0]  nib;
      logic [9:0]  s2, new_deb, rise, clr;
      logic        hit, w, all_diff;
      for (int i = 0; i < 6; i++) begin
         nib = (i < 3) ? m_hlo[4*i +: 4] : m_hhi[4*(i-3) +: 4];
         hx[i] = m_blank[i] ? 8'hFF : {~m_dp[i], glyph[nib]};
      end
      // a switch level moves once the last N synchronised samples all disagree with it
      rawq.push_back(p_sw);
      s2 = (rawq.size() >= 3) ? rawq[rawq.size()-3] : 10'd0;
      while (rawq.size() > 2) void'(rawq.pop_front());
      sq.push_back(s2);
      while (sq.size() > N) void'(sq.pop_front());
      new_deb = m_deb;
      rise = '0;
      for (int b = 0; b < 10; b++) begin
         if (sq.size() == N) begin
            all_diff = 1'b1;
            foreach (sq[j]) if (sq[j][b] == m_deb[b]) all_diff = 1'b0;
            if (all_diff) begin
               new_deb[b] = ~m_deb[b];
               rise[b] = ~m_deb[b];
            end
         end
      end
      hit = (p_addr[15:4] == 12'hFF0);
      w = p_we && hit;
      clr = (w && p_addr[3:0] == 4'h5) ? p_wdata[9:0] : 10'd0;
      m_flags = (m_flags & ~clr) | rise;
      if (TEN) m_timer = (w && p_addr[3:0] == 4'h6) ? p_wdata : m_timer + 16'd1;
      if (w) begin
         case (p_addr[3:0])
            4'h0: m_led = p_wdata[9:0];
            4'h1: m_hlo = p_wdata[11:0];
            4'h2: m_hhi = p_wdata[11:0];
            4'h3: begin m_blank = p_wdata[5:0]; m_dp = p_wdata[13:8]; end
            default: ;
         endcase
      end
      m_deb = new_deb;
      for (int i = 0; i < 6; i++) m_hex[i] = hx[i];
   endtask

   function automatic logic [15:0] exp_rd(input logic [15:0] addr, input logic re);
      if (!(re && addr[15:4] == 12'hFF0)) return 16'd0;
      case (addr[3:0])
         4'h0: return {6'd0, m_led};
         4'h1: return {4'd0, m_hlo};
         4'h2: return {4'd0, m_hhi};
         4'h3: return {2'd0, m_dp, 2'd0, m_blank};
         4'h4: return {6'd0, m_deb};
         4'h5: return {6'd0, m_flags};
         4'h6: return TEN ? m_timer : 16'd0;
         default: return 16'd0;
      endcase
   endfunction

   task automatic step(input logic rst_v, input logic we, input logic re,
                       input logic [15:0] addr, input logic [15:0] wd, input logic [9:0] sw);
      exp_t e;
      @(posedge CLK);
      if (RST) model_edge();
      #1;
      RST = rst_v;
      if (!rst_v) model_reset();
      bus_we = we; bus_re = re; bus_addr = addr; bus_wdata = wd; SW = sw;
      p_we = we; p_addr = addr; p_wdata = wd; p_sw = sw;
      e.rd   = exp_rd(addr, re);
      e.hit  = (addr[15:4] == 12'hFF0);
      e.leds = m_led;
      e.hex  = {m_hex[5], m_hex[4], m_hex[3], m_hex[2], m_hex[1], m_hex[0]};
      q.push_back(e);
   endtask

   task automatic idle(input int n, input logic [9:0] sw);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, sw);
   endtask

   // monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("rdata", {32'd0, bus_rdata}, {32'd0, e.rd});
            chk("bus_hit", {47'd0, bus_hit}, {47'd0, e.hit});
            chk("leds", {38'd0, LEDS}, {38'd0, e.leds});
            chk("hex", {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, e.hex);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "timeout");
   end

   initial begin
      logic [9:0]  sw;
      logic [15:0] a;
      logic [3:0]  o;
      glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      model_reset();
      p_we = 0; p_addr = 0; p_wdata = 0; p_sw = 0;

      // reset, release, read back
      step(1'b0, 0, 0, 16'h0, 16'h0, 10'h0);
      step(1'b0, 0, 0, 16'h0, 16'h0, 10'h0);
      step(1'b1, 0, 1, 16'hFF04, 16'h0, 10'h0);
      step(1'b1, 0, 1, 16'hFF05, 16'h0, 10'h0);
      step(1'b1, 0, 1, 16'hFF06, 16'h0, 10'h0);
      step(1'b1, 0, 1, 16'hFF03, 16'h0, 10'h0);

      // display digits 1..6, then DP on digit 0
      step(1'b1, 1, 0, 16'hFF03, 16'h0000, 10'h0);
      step(1'b1, 1, 0, 16'hFF01, 16'h0321, 10'h0);
      step(1'b1, 1, 0, 16'hFF02, 16'h0654, 10'h0);
      idle(3, 10'h0);
      step(1'b1, 1, 0, 16'hFF03, 16'h0100, 10'h0);
      idle(3, 10'h0);

      // stable switch, then a bouncing switch
      for (int i = 0; i < 22; i++) step(1'b1, 0, 1, (i % 2) ? 16'hFF05 : 16'hFF04, 16'h0, 10'h001);
      sw = 10'h001;
      for (int i = 0; i < 40; i++) begin
         if (i % 5 == 0) sw[1] = ~sw[1];
         step(1'b1, 0, 1, 16'hFF04, 16'h0, sw);
      end
      idle(22, 10'h001);

      // W1C of bit 0 on the edge bit 2 settles
      step(1'b1, 0, 0, 16'h0, 16'h0, 10'h005);
      idle(16, 10'h005);
      step(1'b1, 1, 0, 16'hFF05, 16'h0001, 10'h005);
      step(1'b1, 0, 1, 16'hFF05, 16'h0, 10'h005);
      step(1'b1, 0, 1, 16'hFF04, 16'h0, 10'h005);

      // timer wrap
      step(1'b1, 1, 0, 16'hFF06, 16'hFFFE, 10'h005);
      step(1'b1, 0, 1, 16'hFF06, 16'h0, 10'h005);
      step(1'b1, 0, 1, 16'hFF06, 16'h0, 10'h005);

      // LEDs and an out-of-window store
      step(1'b1, 1, 0, 16'hFF00, 16'h03FF, 10'h005);
      step(1'b1, 1, 1, 16'hFE00, 16'h0000, 10'h005);
      step(1'b1, 0, 1, 16'hFF00, 16'h0, 10'h005);

      // randomized traffic
      sw = 10'h005;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 39) == 0) sw[$urandom_range(0, 9)] ^= 1'b1;
         if ($urandom_range(0, 99) < 5) sw ^= 10'($urandom);
         o = 4'($urandom_range(0, 15));
         a = ($urandom_range(0, 9) < 8) ? {12'hFF0, o} : 16'($urandom);
         step(1'b1, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
              a, 16'($urandom), sw);
      end

      // reset in the middle of a debounce window
      sw = ~sw;
      idle(8, sw);
      step(1'b0, 0, 1, 16'hFF04, 16'h0, sw);
      step(1'b0, 0, 1, 16'hFF05, 16'h0, sw);
      for (int i = 0; i < 24; i++) step(1'b1, 0, 1, (i % 2) ? 16'hFF05 : 16'hFF04, 16'h0, sw);

      idle(2, sw);
      @(negedge CLK);
      @(negedge CLK);
      chk("queue_drain", 48'(q.size()), 48'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
